// File: rtl/fir_mac_sched_if.sv
// Operand/result handshake between the FIR tap sequencer and the shared MAC.
// master = sequencer side, slave = MAC side.
interface fir_mac_sched_if #(
    parameter int in_w_p  = 12,
    parameter int out_w_p = 32
);
    logic [in_w_p-1:0]  mac_a_o;
    logic [in_w_p-1:0]  mac_b_o;
    logic               mac_valid_o;
    logic               mac_ready_i;
    logic [out_w_p-1:0] mac_data_i;
    logic               mac_valid_i;
    logic               mac_ready_o;
    logic               mac_clear_o;

    modport master (
        output mac_a_o, mac_b_o, mac_valid_o, mac_ready_o, mac_clear_o,
        input  mac_ready_i, mac_data_i, mac_valid_i
    );

    modport slave (
        input  mac_a_o, mac_b_o, mac_valid_o, mac_ready_o, mac_clear_o,
        output mac_ready_i, mac_data_i, mac_valid_i
    );
endinterface

// File: rtl/fir_mac_sched.sv
// FIR tap sequencer: shifts each sample into a history line, then walks the taps
// through a shared MAC one (sample, coefficient) pair at a time.
module fir_mac_sched #(
    parameter int taps_p      = 8,
    parameter int int_in_lp   = 1,
    parameter int frac_in_lp  = 11,
    parameter int int_out_lp  = 10,
    parameter int frac_out_lp = 22
) (
    input  logic                              clk_i,
    input  logic                              reset_ni,
    input  logic [int_in_lp+frac_in_lp-1:0]   sample_i,
    input  logic                              sample_valid_i,
    output logic                              sample_ready_o,
    input  logic                              coef_we_i,
    input  logic [$clog2(taps_p)-1:0]         coef_addr_i,
    input  logic [int_in_lp+frac_in_lp-1:0]   coef_data_i,
    fir_mac_sched_if.master                   mac,
    output logic [int_out_lp+frac_out_lp-1:0] data_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic                              busy_o
);
    localparam int IN_W  = int_in_lp + frac_in_lp;
    localparam int OUT_W = int_out_lp + frac_out_lp;
    localparam int AW    = $clog2(taps_p);
    localparam logic [AW-1:0] LAST_K = AW'(taps_p - 1);

    typedef enum logic [2:0] {
        IDLE_S  = 3'd0,
        CLEAR_S = 3'd1,
        ISSUE_S = 3'd2,
        WAIT_S  = 3'd3,
        OUT_S   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     k_q, k_d;
    logic [IN_W-1:0]   hist_q [taps_p];
    logic [IN_W-1:0]   coef_q [taps_p];
    logic [IN_W-1:0]   mac_a_q, mac_b_q;
    logic [OUT_W-1:0]  data_q;
    logic              sample_ready_q, mac_valid_q, mac_ready_q, mac_clear_q;
    logic              valid_q, busy_q;
    logic              accept_s, capture_s;

    // State and tap index register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE_S;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // Next-state logic; mac_valid_i only matters while waiting for a result
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        case (state_q)
            IDLE_S: begin
                if (sample_valid_i) begin
                    accept_s = 1'b1;
                    k_d      = '0;
                    state_d  = CLEAR_S;
                end else begin
                    state_d  = IDLE_S;
                end
            end
            CLEAR_S: state_d = ISSUE_S;
            ISSUE_S: begin
                if (mac.mac_ready_i) begin
                    state_d = WAIT_S;
                end else begin
                    state_d = ISSUE_S;
                end
            end
            WAIT_S: begin
                if (mac.mac_valid_i) begin
                    if (k_q == LAST_K) begin
                        capture_s = 1'b1;
                        state_d   = OUT_S;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = ISSUE_S;
                    end
                end else begin
                    state_d = WAIT_S;
                end
            end
            OUT_S: begin
                if (ready_i) begin
                    state_d = IDLE_S;
                end else begin
                    state_d = OUT_S;
                end
            end
            default: state_d = IDLE_S;
        endcase
    end

    // Sample history line and coefficient register file
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < taps_p; i++) begin
                hist_q[i] <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            if (accept_s) begin
                hist_q[0] <= sample_i;
                for (int i = 1; i < taps_p; i++) begin
                    hist_q[i] <= hist_q[i-1];
                end
            end
            if (coef_we_i && (32'(coef_addr_i) < 32'(taps_p))) begin
                coef_q[coef_addr_i] <= coef_data_i;
            end
        end
    end

    // Operands are loaded on entry to ISSUE so they hold steady through a MAC stall
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mac_a_q <= '0;
            mac_b_q <= '0;
            data_q  <= '0;
        end else begin
            if ((state_d == ISSUE_S) && (state_q != ISSUE_S)) begin
                mac_a_q <= hist_q[k_d];
                mac_b_q <= coef_q[k_d];
            end
            if (capture_s) begin
                data_q <= mac.mac_data_i;
            end
        end
    end

    // Handshake flags registered from the next state
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sample_ready_q <= 1'b1;
            mac_valid_q    <= 1'b0;
            mac_ready_q    <= 1'b0;
            mac_clear_q    <= 1'b0;
            valid_q        <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            sample_ready_q <= (state_d == IDLE_S);
            mac_valid_q    <= (state_d == ISSUE_S);
            mac_ready_q    <= (state_d == WAIT_S);
            mac_clear_q    <= (state_d == CLEAR_S);
            valid_q        <= (state_d == OUT_S);
            busy_q         <= (state_d != IDLE_S);
        end
    end

    assign sample_ready_o  = sample_ready_q;
    assign mac.mac_a_o     = mac_a_q;
    assign mac.mac_b_o     = mac_b_q;
    assign mac.mac_valid_o = mac_valid_q;
    assign mac.mac_ready_o = mac_ready_q;
    assign mac.mac_clear_o = mac_clear_q;
    assign data_o          = data_q;
    assign valid_o         = valid_q;
    assign busy_o          = busy_q;
endmodule

// File: tb/tb_fir_mac_sched.sv
// Bench for fir_mac_sched: an 8-tap DUT driven from a vector table plus a 6-tap DUT
// for out-of-range coefficient addresses, each paired with a behavioural MAC.
module tb_fir_mac_sched;
    logic        clk = 1'b0;
    logic        reset_ni = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] sample_i = 12'h000;
    logic        sample_valid_i = 1'b0, sample_ready_o;
    logic        coef_we_i = 1'b0;
    logic [2:0]  coef_addr_i = 3'd0;
    logic [11:0] coef_data_i = 12'h000;
    logic [31:0] data_o;
    logic        valid_o, busy_o;
    logic        ready_i = 1'b1;

    logic [11:0] sample2 = 12'h000;
    logic        sample_valid2 = 1'b0, sample_ready2;
    logic        coef_we2 = 1'b0;
    logic [2:0]  coef_addr2 = 3'd0;
    logic [11:0] coef_data2 = 12'h000;
    logic [31:0] data2;
    logic        valid2, busy2;

    int total = 0;
    int bad   = 0;

    fir_mac_sched_if #(.in_w_p(12), .out_w_p(32)) mif ();
    fir_mac_sched_if #(.in_w_p(12), .out_w_p(32)) mif2 ();

    fir_mac_sched #(.taps_p(8)) dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .sample_i(sample_i), .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
        .coef_we_i(coef_we_i), .coef_addr_i(coef_addr_i), .coef_data_i(coef_data_i),
        .mac(mif),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o)
    );

    fir_mac_sched #(.taps_p(6)) dut6 (
        .clk_i(clk), .reset_ni(reset_ni),
        .sample_i(sample2), .sample_valid_i(sample_valid2), .sample_ready_o(sample_ready2),
        .coef_we_i(coef_we2), .coef_addr_i(coef_addr2), .coef_data_i(coef_data2),
        .mac(mif2),
        .data_o(data2), .valid_o(valid2), .ready_i(1'b1), .busy_o(busy2)
    );

    // Behavioural MAC: accumulate on operand handshake, present the sum next cycle
    logic signed [31:0] acc1, acc2;
    logic               rv1, rv2;
    assign mif.mac_data_i   = acc1;
    assign mif.mac_valid_i  = rv1;
    assign mif2.mac_data_i  = acc2;
    assign mif2.mac_valid_i = rv2;
    assign mif2.mac_ready_i = 1'b1;

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            acc1 <= 32'sd0; rv1 <= 1'b0;
        end else if (mif.mac_clear_o) begin
            acc1 <= 32'sd0; rv1 <= 1'b0;
        end else if (mif.mac_valid_o && mif.mac_ready_i) begin
            acc1 <= acc1 + {{20{mif.mac_a_o[11]}}, mif.mac_a_o} * {{20{mif.mac_b_o[11]}}, mif.mac_b_o};
            rv1  <= 1'b1;
        end else if (rv1 && mif.mac_ready_o) begin
            rv1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            acc2 <= 32'sd0; rv2 <= 1'b0;
        end else if (mif2.mac_clear_o) begin
            acc2 <= 32'sd0; rv2 <= 1'b0;
        end else if (mif2.mac_valid_o && mif2.mac_ready_i) begin
            acc2 <= acc2 + {{20{mif2.mac_a_o[11]}}, mif2.mac_a_o} * {{20{mif2.mac_b_o[11]}}, mif2.mac_b_o};
            rv2  <= 1'b1;
        end else if (rv2 && mif2.mac_ready_o) begin
            rv2 <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_ni = 1'b0;
        @(negedge clk);
        reset_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_coef(input logic [2:0] a, input logic [11:0] d);
        coef_addr_i = a; coef_data_i = d; coef_we_i = 1'b1;
        @(negedge clk);
        coef_we_i = 1'b0;
    endtask

    task automatic write_coef2(input logic [2:0] a, input logic [11:0] d);
        coef_addr2 = a; coef_data2 = d; coef_we2 = 1'b1;
        @(negedge clk);
        coef_we2 = 1'b0;
    endtask

    // One full transaction on the 8-tap DUT with optional MAC stall and output backpressure
    task automatic run_sample(input logic [11:0] s, input int stall_tap, input int stall_n,
                              input int bp_n, input logic [11:0] ea, input logic [11:0] eb,
                              output logic [31:0] res, output int lat);
        int   cyc, issues, stalls, bps, clears;
        logic done;
        logic [31:0] held;
        cyc = 0; issues = 0; stalls = 0; bps = 0; clears = 0; done = 1'b0;
        held = 32'h0; lat = -1;
        chk("idle_ready", {31'd0, sample_ready_o}, 32'd1);
        sample_i = s; sample_valid_i = 1'b1;
        @(negedge clk);
        sample_valid_i = 1'b0;
        cyc = 1;
        while (!done && cyc < 300) begin
            if (mif.mac_clear_o) clears++;
            mif.mac_ready_i = 1'b1;
            ready_i = 1'b1;
            if (mif.mac_valid_o) begin
                if (issues == stall_tap && stalls < stall_n) begin
                    mif.mac_ready_i = 1'b0;
                    stalls++;
                    chk("stall_a", {20'd0, mif.mac_a_o}, {20'd0, ea});
                    chk("stall_b", {20'd0, mif.mac_b_o}, {20'd0, eb});
                end else begin
                    issues++;
                end
            end
            if (valid_o) begin
                if (lat < 0) begin
                    lat  = cyc;
                    held = data_o;
                end
                if (bps < bp_n) begin
                    ready_i = 1'b0;
                    bps++;
                    chk("bp_data_hold", data_o, held);
                    chk("bp_sample_ready", {31'd0, sample_ready_o}, 32'd0);
                    chk("bp_mac_valid", {31'd0, mif.mac_valid_o}, 32'd0);
                    chk("bp_mac_clear", {31'd0, mif.mac_clear_o}, 32'd0);
                end else begin
                    done = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        ready_i = 1'b1;
        mif.mac_ready_i = 1'b1;
        chk("completed", {31'd0, done}, 32'd1);
        chk("back_idle", {30'd0, busy_o, valid_o}, 32'd0);
        chk("clear_pulses", 32'(clears), 32'd1);
        if (bp_n > 0) chk("bp_cycles", 32'(bps), 32'(bp_n));
        res = held;
    endtask

    task automatic run6(input logic [11:0] s, input logic [31:0] exp);
        int cyc;
        cyc = 0;
        sample2 = s; sample_valid2 = 1'b1;
        @(negedge clk);
        sample_valid2 = 1'b0;
        cyc = 1;
        while (!valid2 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("t6_latency", 32'(cyc), 32'd14);
        chk("t6_data", data2, exp);
        @(negedge clk);
    endtask

    typedef struct {
        int          setup;
        logic [11:0] s;
        int          stall_tap;
        int          stall_n;
        int          bp_n;
        logic [11:0] ea;
        logic [11:0] eb;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [31:0] r;
        int          l;
        int          cyc;

        vecs[0] = '{1, 12'h400, -1, 0, 0, 12'h000, 12'h000, 32'h0010_0000, 18};
        vecs[1] = '{0, 12'h000, -1, 0, 0, 12'h000, 12'h000, 32'h0010_0000, 18};
        vecs[2] = '{2, 12'h800, -1, 0, 0, 12'h000, 12'h000, 32'hFFFF_8000, 18};
        vecs[3] = '{0, 12'h000, -1, 0, 0, 12'h000, 12'h000, 32'hFFFF_0000, 18};
        vecs[4] = '{0, 12'h000, -1, 0, 0, 12'h000, 12'h000, 32'hFFFE_8000, 18};
        vecs[5] = '{0, 12'h000,  3, 4, 0, 12'h800, 12'h040, 32'hFFFE_0000, 22};
        vecs[6] = '{0, 12'h000, -1, 0, 5, 12'h000, 12'h000, 32'hFFFD_8000, 18};
        vecs[7] = '{0, 12'h000, -1, 0, 0, 12'h000, 12'h000, 32'hFFFD_0000, 18};
        vecs[8] = '{0, 12'h000, -1, 0, 0, 12'h000, 12'h000, 32'hFFFC_8000, 18};
        vecs[9] = '{0, 12'h000, -1, 0, 0, 12'h000, 12'h000, 32'hFFFC_0000, 18};

        mif.mac_ready_i = 1'b1;
        #12;
        chk("rst_sample_ready", {31'd0, sample_ready_o}, 32'd1);
        chk("rst_flags", {27'd0, busy_o, valid_o, mif.mac_valid_o, mif.mac_ready_o, mif.mac_clear_o}, 32'd0);
        chk("rst_data", data_o, 32'd0);
        @(negedge clk);
        reset_ni = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].setup == 1) begin
                do_reset();
                for (int k = 0; k < 8; k++) write_coef(3'(k), 12'h400);
            end else if (vecs[i].setup == 2) begin
                do_reset();
                for (int k = 0; k < 8; k++) write_coef(3'(k), 12'((k + 1) * 16));
            end
            run_sample(vecs[i].s, vecs[i].stall_tap, vecs[i].stall_n, vecs[i].bp_n,
                       vecs[i].ea, vecs[i].eb, r, l);
            chk($sformatf("vec%0d_data", i), r, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(l), 32'(vecs[i].lat));
        end

        // Reset in the middle of a run, during ISSUE at k=4
        do_reset();
        for (int k = 0; k < 8; k++) write_coef(3'(k), 12'h400);
        run_sample(12'h400, -1, 0, 0, 12'h000, 12'h000, r, l);
        chk("pre_rst_data", r, 32'h0010_0000);
        sample_i = 12'h400; sample_valid_i = 1'b1;
        @(negedge clk);
        sample_valid_i = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrun_issue", {31'd0, mif.mac_valid_o}, 32'd1);
        reset_ni = 1'b0;
        #1;
        chk("midrun_rst_ready", {31'd0, sample_ready_o}, 32'd1);
        chk("midrun_rst_flags", {27'd0, busy_o, valid_o, mif.mac_valid_o, mif.mac_ready_o, mif.mac_clear_o}, 32'd0);
        chk("midrun_rst_data", data_o, 32'd0);
        @(negedge clk);
        reset_ni = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) write_coef(3'(k), 12'h400);
        run_sample(12'h200, -1, 0, 0, 12'h000, 12'h000, r, l);
        chk("post_rst_data", r, 32'h0008_0000);
        chk("post_rst_latency", 32'(l), 32'd18);

        // Out-of-range coefficient addresses on the 6-tap instance
        do_reset();
        for (int k = 0; k < 6; k++) write_coef2(3'(k), 12'h400);
        write_coef2(3'd6, 12'h7FF);
        write_coef2(3'd7, 12'h7FF);
        run6(12'h400, 32'h0010_0000);
        run6(12'h400, 32'h0020_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
